// File: rtl/cam_pkg.sv
//==============================================================================
// Module      : cam_pkg
// Description : Shared definitions for the camera capture path: OV7670 QQVGA
//               geometry, capture FSM state encoding and RGB565->RGB332 packing.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package cam_pkg;

   // OV7670 QQVGA output geometry
   localparam int QQVGA_H_PIX   = 160;
   localparam int QQVGA_V_LINES = 120;

   // Capture FSM state encoding
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WAIT_VS = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE    = ST_IDLE,
      S_WAIT_VS = ST_WAIT_VS,
      S_CAPTURE = ST_CAPTURE,
      S_DONE    = ST_DONE
   } cap_state_t;

   // RGB565 arrives high byte first (RRRRRGGG, GGGBBBBB); keep the top
   // 3 bits of red, top 3 bits of green and top 2 bits of blue.
   function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] hi,
                                                   input logic [7:0] lo);
      return {hi[7:5], hi[2:0], lo[4:3]};
   endfunction

endpackage

`default_nettype wire

// File: rtl/cam_sync_edge.sv
//==============================================================================
// Module      : cam_sync_edge
// Description : Two-flop synchronizer for an asynchronous camera control line,
//               with a third flop providing one-cycle rise/fall pulses.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cam_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q,
   output logic o_rise,
   output logic o_fall
);

   logic r_s1;
   logic r_s2;
   logic r_s3;

   // Synchronizer chain plus one history flop for edge detection
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign o_q    = r_s2;
   assign o_rise = r_s2 & ~r_s3;
   assign o_fall = ~r_s2 & r_s3;

endmodule

`default_nettype wire

// File: rtl/cam_frame_capture.sv
//==============================================================================
// Module      : cam_frame_capture
// Description : Samples the OV7670 parallel bus in the system clock domain,
//               assembles RGB565 byte pairs, packs them to RGB332 and writes
//               exactly one frame into the frame buffer per accepted arm.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cam_frame_capture
   import cam_pkg::*;
#(
   parameter int H_PIX   = QQVGA_H_PIX,
   parameter int V_LINES = QQVGA_V_LINES,
   parameter int ADDR_W  = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pclk,
   input  logic              vsync,
   input  logic              href,
   input  logic [7:0]        din,
   input  logic              arm,
   output logic              busy,
   output logic              done,
   output logic              frame_err,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data
);

   // Line counter is wide enough to reach V_LINES+1 and saturates, so a
   // runaway camera can never wrap back to a "correct" count.
   localparam int                LINE_W  = $clog2(V_LINES + 2);
   localparam logic [ADDR_W:0]   c_TOTAL = (ADDR_W + 1)'(H_PIX * V_LINES);
   localparam logic [LINE_W-1:0] c_LINES = LINE_W'(V_LINES);

   logic              w_pclk_s, w_pclk_rise, w_pclk_fall;
   logic              w_href_s, w_href_rise, w_href_fall;
   logic              w_vsync_s, w_vsync_rise, w_vsync_fall;
   logic              w_unused;

   logic [7:0]        r_din1;
   logic [7:0]        r_din2;
   cap_state_t        r_state;
   logic              r_phase;
   logic [7:0]        r_hi_byte;
   logic [ADDR_W:0]   r_pix_cnt;
   logic [LINE_W-1:0] r_line_cnt;

   logic              w_byte_ok;
   logic              w_pix_full;
   logic              w_pix_write;
   logic [ADDR_W:0]   w_pix_next;

   cam_sync_edge u_sync_pclk (
      .clk    (clk),
      .reset  (reset),
      .i_d    (pclk),
      .o_q    (w_pclk_s),
      .o_rise (w_pclk_rise),
      .o_fall (w_pclk_fall)
   );

   cam_sync_edge u_sync_href (
      .clk    (clk),
      .reset  (reset),
      .i_d    (href),
      .o_q    (w_href_s),
      .o_rise (w_href_rise),
      .o_fall (w_href_fall)
   );

   cam_sync_edge u_sync_vsync (
      .clk    (clk),
      .reset  (reset),
      .i_d    (vsync),
      .o_q    (w_vsync_s),
      .o_rise (w_vsync_rise),
      .o_fall (w_vsync_fall)
   );

   // Only the pulses below are consumed; the remaining sync outputs are idle.
   assign w_unused = ^{w_pclk_s, w_pclk_fall, w_href_rise, w_vsync_s};

   // Data bus gets the same two-flop delay as pclk so it lines up with pclk_rise
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_din1 <= 8'h00;
         r_din2 <= 8'h00;
      end else begin
         r_din1 <= din;
         r_din2 <= r_din1;
      end
   end

   // Byte-accept and pixel-write qualifiers for the current cycle
   always_comb begin
      w_byte_ok   = (r_state == S_CAPTURE) && w_pclk_rise && w_href_s;
      w_pix_full  = (r_pix_cnt == c_TOTAL);
      w_pix_write = w_byte_ok && r_phase && !w_pix_full;
      w_pix_next  = r_pix_cnt + {{ADDR_W{1'b0}}, w_pix_write};
   end

   // Capture FSM with registered status and frame-buffer write outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_phase    <= 1'b0;
         r_hi_byte  <= 8'h00;
         r_pix_cnt  <= '0;
         r_line_cnt <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         frame_err  <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_data   <= 8'h00;
      end else begin
         mem_we <= 1'b0;
         done   <= 1'b0;
         // Address advances the cycle after each strobe, so it always
         // names the next pixel to be written.
         if (mem_we) begin
            mem_addr <= mem_addr + ADDR_W'(1);
         end

         case (r_state)
            S_IDLE: begin
               if (arm) begin
                  r_state   <= S_WAIT_VS;
                  busy      <= 1'b1;
                  frame_err <= 1'b0;
               end
            end

            // Falling vsync marks the end of blanking; anything earlier
            // would be a partial frame.
            S_WAIT_VS: begin
               if (w_vsync_fall) begin
                  r_state    <= S_CAPTURE;
                  r_pix_cnt  <= '0;
                  r_line_cnt <= '0;
                  r_phase    <= 1'b0;
                  mem_addr   <= '0;
               end
            end

            S_CAPTURE: begin
               if (w_byte_ok) begin
                  if (!r_phase) begin
                     r_hi_byte <= r_din2;
                     r_phase   <= 1'b1;
                  end else begin
                     r_phase <= 1'b0;
                     if (w_pix_full) begin
                        frame_err <= 1'b1;
                     end else begin
                        mem_we    <= 1'b1;
                        mem_data  <= rgb565_to_rgb332(r_hi_byte, r_din2);
                        r_pix_cnt <= w_pix_next;
                     end
                  end
               end
               // End of line: a dangling high byte means the line was odd
               if (w_href_fall) begin
                  if (r_line_cnt != '1) begin
                     r_line_cnt <= r_line_cnt + LINE_W'(1);
                  end
                  r_phase <= 1'b0;
                  if (r_phase) begin
                     frame_err <= 1'b1;
                  end
               end
               // End of frame; a write in this same cycle still lands
               if (w_vsync_rise) begin
                  r_state <= S_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  if ((w_pix_next != c_TOTAL) || (r_line_cnt != c_LINES)) begin
                     frame_err <= 1'b1;
                  end
               end
            end

            S_DONE: begin
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/cam_frame_capture.md
Name: cam_frame_capture

Overview:
- Write side of the camera path.
- Samples the OV7670 parallel pixel bus (pclk/href/vsync/din) in the system clock domain.
- Assembles RGB565 byte pairs into pixels, packs each pixel to RGB332, and writes exactly one frame into an on-chip frame buffer.
- The frame buffer is later read out by the FIFO/readout logic; this block is its producer.

Parameters:
- H_PIX, 160, pixels per line (QQVGA).
- V_LINES, 120, lines per frame.
- ADDR_W, 15, frame buffer address width; must satisfy 2^ADDR_W >= H_PIX*V_LINES.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-low reset.
- pclk  in  1  camera pixel clock, asynchronous; must be <= clk/4.
- vsync  in  1  camera frame sync, active-high blanking pulse.
- href  in  1  camera line valid.
- din  in  8  camera data byte.
- arm  in  1  request capture of the next full frame (level, sampled in IDLE).
- busy  out  1  high from accepted arm until done.
- done  out  1  one-cycle pulse at end of capture.
- frame_err  out  1  pixel/line count mismatch on last frame; held until next accepted arm.
- mem_we  out  1  frame buffer write strobe, one cycle per pixel.
- mem_addr  out  ADDR_W  frame buffer write address.
- mem_data  out  8  RGB332 pixel.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE; busy=0, done=0, frame_err=0, mem_we=0, mem_addr=0, mem_data=0; all syncs, counters and phase cleared. Reset mid-frame aborts with no done pulse.
- Input sync: pclk, vsync, href pass through 2 flops. din passes through 2 flops, aligned with synced pclk.
- Edge detect uses a third flop.
- pclk_rise is a one-cycle event. Data is sampled on pclk_rise using the synced din.
- FSM IDLE: arm==1 -> WAIT_VS; busy=1; frame_err cleared.
- FSM WAIT_VS: wait for vsync_s falling edge (end of blanking = frame start) -> CAPTURE; pix_cnt=0, line_cnt=0, phase=0, mem_addr=0. Entering mid-frame (vsync low at arm) waits for the following falling edge. A partial frame is never captured.
- FSM CAPTURE, pixel assembly: on pclk_rise with href_s==1:
  - phase 0: hi_byte<=din_s, phase<=1.
  - phase 1: mem_data<={hi_byte[7:5], hi_byte[2:0], din_s[4:3]}, mem_we=1 for exactly one clk, phase<=0.
  - mem_addr equals the pixel index during the strobe and increments by 1 the cycle after the strobe.
- FSM CAPTURE, overflow: once pix_cnt==H_PIX*V_LINES, further pixels are dropped (no mem_we). frame_err is set; mem_addr never wraps.
- FSM CAPTURE, line end: href_s falling edge -> line_cnt++, phase<=0. An odd trailing byte is discarded and frame_err is set.
- FSM CAPTURE, frame end: vsync_s rising edge -> DONE. frame_err is set if pix_cnt != H_PIX*V_LINES or line_cnt != V_LINES.
- FSM DONE: done=1 for one cycle, busy=0 -> IDLE.
- Simultaneous events:
  - pclk_rise coincident with href_s fall: the byte is ignored (href_s low).
  - vsync_s rise coincident with a pixel write: the write completes, then DONE.
- arm is ignored outside IDLE.
- Latency: din on pad to mem_we <= 4 clk after pclk rise.

Decomposition:
- Shared package cam_pkg:
  - RGB565->RGB332 packing function.
  - State encoding localparams (IDLE, WAIT_VS, CAPTURE, DONE).
  - OV7670 QQVGA constants (160, 120).
- Sub-module cam_sync_edge: 2-flop synchronizer plus rise/fall pulse generator. Instantiated for pclk, href, vsync.

Test Plan:
- Full frame: arm=1, model emits vsync pulse then 120 lines x 320 bytes at pclk=clk/4 -> 19200 mem_we strobes, addresses 0..19199, one done pulse, frame_err=0.
- Packing: byte pair 0xF8,0x1F (RGB565 red+blue) -> mem_data=0xE3. Pair 0x07,0xE0 (green) -> 0x1C.
- Arm mid-frame: arm asserted during line 50 -> no writes until next vsync falling edge; then a complete frame, addresses start at 0.
- Short frame: 119 lines then vsync -> 19040 writes, done pulse, frame_err=1. Next arm clears frame_err.
- Odd bytes/overflow: line with 321 bytes -> 160 writes for that line, frame_err=1. A 121st line -> no writes beyond addr 19199.
- Reset mid-CAPTURE: reset=0 for 1 clk at pixel 5000 -> busy=0, mem_we=0, mem_addr=0, no done pulse. Re-arm captures a full frame correctly.
